// File: rtl/br_lite_local_port.sv
// BrLite local-port adapter: a TX FIFO stamps PE requests and injects them with req/ack,
// and an RX FIFO captures router flits with a one-cycle ack and presents them valid/ready.
package br_lite_pkg;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_MON   = 2'd3
  } br_service_t;

  localparam int BR_ID_W      = 5;
  localparam int BR_PAYLOAD_W = 32;

  typedef struct packed {
    br_service_t              service;
    logic [15:0]              seq_source;
    logic [15:0]              seq_target;
    logic [BR_ID_W-1:0]       id;
    logic [BR_PAYLOAD_W-1:0]  payload;
  } br_data_t;

endpackage

module br_lite_local_port
  import br_lite_pkg::*;
#(
  parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  br_service_t             tx_service_i,
  input  logic [15:0]             tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_err_o,
  input  logic                    local_busy_i,
  output br_data_t                flit_o,
  output logic                    req_o,
  input  logic                    ack_i,
  input  br_data_t                flit_i,
  input  logic                    req_i,
  output logic                    ack_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_data_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_t;

  // ---------------------------------------------------------------- TX path
  br_data_t           tx_mem [TX_DEPTH];
  logic [TX_AW:0]     tx_wr_ptr, tx_rd_ptr;
  logic [BR_ID_W-1:0] id_cnt;
  tx_state_t          tx_state;
  br_data_t           tx_entry;
  logic               tx_full, tx_empty, tx_push, tx_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && !tx_full && (tx_service_i != BR_SVC_CLEAR);
  assign tx_pop     = (tx_state == TX_REQ) && ack_i;

  assign tx_entry = '{service:    tx_service_i,
                      seq_source: SEQ_ADDRESS,
                      seq_target: tx_target_i,
                      id:         id_cnt,
                      payload:    tx_payload_i};

  // NOTE: storage arrays are not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= tx_entry;
  end

  // NOTE: every register uses <= so all updates take effect together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      id_cnt    <= '0;
      tx_err_o  <= 1'b0;
    end else begin
      tx_err_o <= tx_valid_i && !tx_full && (tx_service_i == BR_SVC_CLEAR);
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
        id_cnt    <= id_cnt + BR_ID_W'(1);
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
    end
  end

  // The head stays in the FIFO until acked, so flit_o is a stable snapshot of it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= TX_IDLE;
      req_o    <= 1'b0;
      flit_o   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !local_busy_i) begin
            flit_o   <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
            req_o    <= 1'b1;
            tx_state <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (ack_i) begin
            req_o    <= 1'b0;
            tx_state <= TX_GAP;
          end
        end
        TX_GAP:  tx_state <= TX_IDLE;
        default: begin
          req_o    <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  br_data_t       rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
  rx_state_t      rx_state;
  logic           rx_full, rx_empty, rx_push, rx_pop;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_push  = (rx_state == RX_IDLE) && req_i && !rx_full;
  assign rx_pop   = !rx_empty && rx_ready_i;

  assign rx_valid_o = !rx_empty;
  assign rx_data_o  = rx_empty ? '0 : rx_mem[rx_rd_ptr[RX_AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= flit_i;
  end

  // Capture only from RX_IDLE; RX_WAIT absorbs a router req that is still high after ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state  <= RX_IDLE;
      ack_o     <= 1'b0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
      case (rx_state)
        RX_IDLE: begin
          if (rx_push) begin
            ack_o    <= 1'b1;
            rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          ack_o    <= 1'b0;
          rx_state <= RX_WAIT;
        end
        RX_WAIT: begin
          if (!req_i) rx_state <= RX_IDLE;
        end
        default: begin
          ack_o    <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_lite_local_port.sv
// Self-checking bench for br_lite_local_port: directed scenarios plus a randomized TX run,
// all compared against queue-based expectations built from the port's documented rules.
module tb_br_lite_local_port;
  import br_lite_pkg::*;

  localparam logic [15:0] SEQ      = 16'h0005;
  localparam int          TX_DEPTH = 4;
  localparam int          RX_DEPTH = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    tx_valid_i = 1'b0;
  logic                    tx_ready_o;
  br_service_t             tx_service_i = BR_SVC_ALL;
  logic [15:0]             tx_target_i = '0;
  logic [BR_PAYLOAD_W-1:0] tx_payload_i = '0;
  logic                    tx_err_o;
  logic                    local_busy_i = 1'b0;
  br_data_t                flit_o;
  logic                    req_o;
  logic                    ack_i = 1'b0;
  br_data_t                flit_i = '0;
  logic                    req_i = 1'b0;
  logic                    ack_o;
  logic                    rx_valid_o;
  logic                    rx_ready_i = 1'b0;
  br_data_t                rx_data_o;

  br_lite_local_port #(.SEQ_ADDRESS(SEQ), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_service_i(tx_service_i),
    .tx_target_i(tx_target_i), .tx_payload_i(tx_payload_i), .tx_err_o(tx_err_o),
    .local_busy_i(local_busy_i), .flit_o(flit_o), .req_o(req_o), .ack_i(ack_i),
    .flit_i(flit_i), .req_i(req_i), .ack_o(ack_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  br_data_t           tx_q[$];
  br_data_t           rx_q[$];
  logic [BR_ID_W-1:0] model_id = '0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_flit(input string tag, input br_data_t obs, input br_data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic br_data_t mk(input br_service_t s, input logic [15:0] t,
                                  input logic [31:0] p, input logic [BR_ID_W-1:0] id);
    br_data_t d;
    d.service    = s;
    d.seq_source = SEQ;
    d.seq_target = t;
    d.id         = id;
    d.payload    = p;
    return d;
  endfunction

  function automatic br_data_t rand_flit();
    br_data_t d;
    d.service    = br_service_t'(2'($urandom_range(0, 3)));
    d.seq_source = 16'($urandom);
    d.seq_target = 16'($urandom);
    d.id         = BR_ID_W'($urandom);
    d.payload    = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tx_valid_i = 1'b0; ack_i = 1'b0; req_i = 1'b0;
    local_busy_i = 1'b0; rx_ready_i = 1'b0; flit_i = '0;
    tx_q.delete(); rx_q.delete(); model_id = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One push attempt; the expectation queue takes it only if a real push would happen.
  task automatic push(input br_service_t s, input logic [15:0] t, input logic [31:0] p);
    logic rdy;
    rdy = (tx_q.size() < TX_DEPTH);
    check_bit("tx_ready", tx_ready_o, rdy);
    tx_valid_i = 1'b1; tx_service_i = s; tx_target_i = t; tx_payload_i = p;
    tick();
    tx_valid_i = 1'b0;
    if (rdy && s != BR_SVC_CLEAR) begin
      tx_q.push_back(mk(s, t, p, model_id));
      model_id++;
    end
    check_bit("tx_err", tx_err_o, rdy && (s == BR_SVC_CLEAR));
  endtask

  // Router side of the local input: wait for req, check the flit, ack it.
  task automatic drain_one(output br_data_t got);
    for (int i = 0; i < 100 && !req_o; i++) tick();
    check_bit("req_timeout", req_o, 1'b1);
    got = flit_o;
    if (tx_q.size() > 0) begin
      check_flit("tx_flit", flit_o, tx_q[0]);
      void'(tx_q.pop_front());
    end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check_bit("req_drop", req_o, 1'b0);
  endtask

  // Router side of the local output: hold req until ack, optionally hold it longer.
  task automatic rx_send(input br_data_t d, input int hold_extra);
    logic extra_ack;
    flit_i = d; req_i = 1'b1;
    for (int i = 0; i < 100 && !ack_o; i++) tick();
    check_bit("rx_ack_timeout", ack_o, 1'b1);
    rx_q.push_back(d);
    check_bit("rx_valid", rx_valid_o, 1'b1);
    check_flit("rx_head", rx_data_o, rx_q[0]);
    extra_ack = 1'b0;
    for (int i = 0; i < hold_extra; i++) begin
      tick();
      extra_ack |= ack_o;
    end
    req_i = 1'b0;
    tick();
    extra_ack |= ack_o;
    check_bit("rx_single_ack", extra_ack, 1'b0);
    tick();
  endtask

  task automatic rx_pop();
    check_bit("rx_pop_valid", rx_valid_o, 1'b1);
    if (rx_q.size() > 0) check_flit("rx_pop_data", rx_data_o, rx_q[0]);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
  endtask

  initial begin
    br_data_t    got, d;
    logic        any, rdy_exp, err_exp, prev_req, prev_busy;
    br_service_t svc;
    logic [15:0] tgt;
    logic [31:0] pl;
    logic [BR_ID_W-1:0] id_before;

    // Outputs while reset is held.
    #12;
    check_bit("rst_req", req_o, 1'b0);
    check_bit("rst_ack", ack_o, 1'b0);
    check_bit("rst_rx_valid", rx_valid_o, 1'b0);
    check_bit("rst_tx_err", tx_err_o, 1'b0);
    check_flit("rst_flit", flit_o, '0);
    check_bit("rst_tx_ready", tx_ready_o, 1'b1);
    do_reset();

    // Single push: two cycles to req_o, stamped with source address and id 0.
    push(BR_SVC_ALL, 16'h0102, 32'h0000_00AB);
    check_bit("lat_cycle1", req_o, 1'b0);
    tick();
    check_bit("lat_cycle2", req_o, 1'b1);
    check_bit("seq_source", flit_o.seq_source == SEQ, 1'b1);
    drain_one(got);
    check_bit("single_id0", got.id == '0, 1'b1);
    check_bit("single_ready", tx_ready_o, 1'b1);

    // Busy gating between two queued flits.
    do_reset();
    push(BR_SVC_TGT, 16'h0011, 32'h1111_0001);
    push(BR_SVC_ALL, 16'h0022, 32'h2222_0002);
    drain_one(got);
    local_busy_i = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      any |= req_o;
    end
    check_bit("busy_no_req", any, 1'b0);
    local_busy_i = 1'b0;
    drain_one(got);
    check_bit("busy_second_id1", got.id == BR_ID_W'(1), 1'b1);

    // Back-pressure: busy keeps every entry queued; the fifth push is refused.
    do_reset();
    local_busy_i = 1'b1;
    for (int i = 0; i < TX_DEPTH + 1; i++) push(BR_SVC_TGT, 16'(i), $urandom);
    check_bit("full_not_ready", tx_ready_o, 1'b0);
    local_busy_i = 1'b0;
    while (tx_q.size() > 0) drain_one(got);
    repeat (4) tick();
    check_bit("full_extra_not_sent", req_o, 1'b0);

    // Id wrap over 2^idwidth + 1 transfers.
    do_reset();
    for (int i = 0; i < (1 << BR_ID_W) + 1; i++) begin
      push(($urandom_range(0, 1) != 0) ? BR_SVC_ALL : BR_SVC_TGT, 16'($urandom), $urandom);
      drain_one(got);
    end
    check_bit("id_wrap_zero", got.id == '0, 1'b1);

    // CLEAR push: one-cycle error pulse, nothing queued, id not consumed.
    push(BR_SVC_TGT, 16'h0033, 32'h0000_0033);
    drain_one(got);
    id_before = model_id;
    push(BR_SVC_CLEAR, 16'h0044, 32'h0000_0044);
    tick();
    check_bit("clear_pulse_end", tx_err_o, 1'b0);
    repeat (3) tick();
    check_bit("clear_no_req", req_o, 1'b0);
    push(BR_SVC_ALL, 16'h0055, 32'h0000_0055);
    drain_one(got);
    check_bit("clear_id_kept", got.id == id_before, 1'b1);

    // Randomized TX traffic with random busy and ack timing.
    do_reset();
    err_exp = 1'b0; prev_req = 1'b0; prev_busy = 1'b0;
    for (int n = 0; n < 200; n++) begin
      check_bit("rnd_tx_ready", tx_ready_o, tx_q.size() < TX_DEPTH);
      check_bit("rnd_tx_err", tx_err_o, err_exp);
      if (req_o && tx_q.size() > 0) check_flit("rnd_flit", flit_o, tx_q[0]);
      if (req_o && !prev_req) check_bit("rnd_busy_gate", prev_busy, 1'b0);
      svc = br_service_t'(2'($urandom_range(0, 3)));
      tgt = 16'($urandom);
      pl  = $urandom;
      tx_valid_i   = ($urandom_range(0, 2) == 0);
      tx_service_i = svc; tx_target_i = tgt; tx_payload_i = pl;
      local_busy_i = ($urandom_range(0, 3) == 0);
      ack_i        = req_o && ($urandom_range(0, 1) != 0);
      rdy_exp = (tx_q.size() < TX_DEPTH);
      err_exp = tx_valid_i && rdy_exp && (svc == BR_SVC_CLEAR);
      if (ack_i && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_valid_i && rdy_exp && svc != BR_SVC_CLEAR) begin
        tx_q.push_back(mk(svc, tgt, pl, model_id));
        model_id++;
      end
      prev_req  = req_o;
      prev_busy = local_busy_i;
      tick();
    end
    tx_valid_i = 1'b0; ack_i = 1'b0; local_busy_i = 1'b0;
    while (tx_q.size() > 0) drain_one(got);

    // RX: one ack per flit even with req held high, then fill and back-pressure.
    do_reset();
    check_bit("rx_empty_after_reset", rx_valid_o, 1'b0);
    rx_send(rand_flit(), 5);
    rx_pop();
    check_bit("rx_no_duplicate", rx_valid_o, 1'b0);
    for (int i = 0; i < RX_DEPTH; i++) rx_send(rand_flit(), i);
    d = rand_flit();
    flit_i = d; req_i = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any |= ack_o;
    end
    check_bit("rx_full_withhold", any, 1'b0);
    rx_pop();
    for (int i = 0; i < 10 && !ack_o; i++) tick();
    check_bit("rx_ack_after_pop", ack_o, 1'b1);
    rx_q.push_back(d);
    req_i = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < RX_DEPTH; i++) rx_pop();
    check_bit("rx_drained", rx_valid_o, 1'b0);

    // Reset in the middle of a TX request and an RX wait.
    do_reset();
    push(BR_SVC_TGT, 16'h0066, 32'h0000_0066);
    for (int i = 0; i < 10 && !req_o; i++) tick();
    flit_i = rand_flit(); req_i = 1'b1;
    for (int i = 0; i < 10 && !ack_o; i++) tick();
    tick();
    check_bit("mid_req_high", req_o, 1'b1);
    check_bit("mid_rx_valid", rx_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_bit("async_req", req_o, 1'b0);
    check_bit("async_ack", ack_o, 1'b0);
    check_bit("async_rx_valid", rx_valid_o, 1'b0);
    check_flit("async_flit", flit_o, '0);
    do_reset();
    tick();
    check_bit("post_rst_ready", tx_ready_o, 1'b1);
    check_bit("post_rst_rx", rx_valid_o, 1'b0);
    check_bit("post_rst_req", req_o, 1'b0);
    push(BR_SVC_ALL, 16'h0077, 32'h0000_0077);
    drain_one(got);
    check_bit("post_rst_id0", got.id == '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/br_lite_local_port.md
Name: br_lite_local_port

Overview:
- Local-port adapter between a processing element (PE) and the local port of a BrLite router.
- TX path: buffers PE broadcast/unicast requests in a FIFO and stamps each with source address and message id. It then injects them into the router local input using the router's req/ack protocol, never while the router reports local_busy.
- RX path: accepts flits the router delivers on its local output, acknowledges them with a single-cycle ack, and buffers them for the PE behind a valid/ready interface.

Parameters:
- SEQ_ADDRESS, 16'h0000, sequential address of this PE; written into seq_source of every injected flit.
- TX_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- tx_valid_i  in  1  PE request valid
- tx_ready_o  out  1  TX FIFO can accept (= !tx_full)
- tx_service_i  in  br_service_t  requested service (BR_SVC_ALL or target service)
- tx_target_i  in  16  seq_target of request
- tx_payload_i  in  payload field width of br_data_t  request payload
- tx_err_o  out  1  one-cycle pulse: rejected push (service == BR_SVC_CLEAR)
- local_busy_i  in  1  router local_busy output
- flit_o  out  br_data_t  flit to router local input
- req_o  out  1  request to router local input
- ack_i  in  1  ack from router local input
- flit_i  in  br_data_t  flit from router local output
- req_i  in  1  request from router local output
- ack_o  out  1  ack to router local output
- rx_valid_o  out  1  RX FIFO head valid
- rx_ready_i  in  1  PE pops RX head
- rx_data_o  out  br_data_t  RX FIFO head

Behaviour:
- Clock and reset: single clock domain.
  - Reset is asynchronous, active-low.
  - Reset clears both FIFOs, the id counter, and both FSMs.
  - All outputs are 0 during reset: req_o, ack_o, rx_valid_o, tx_err_o, flit_o.
  - tx_ready_o is 1 after reset.
  - Reset mid-transfer abandons the transfer and discards buffered entries.
- Push:
  - On tx_valid_i && tx_ready_o && service != BR_SVC_CLEAR, enqueue {service, target, payload, seq_source = SEQ_ADDRESS, id = id_cnt}, then id_cnt += 1.
  - id_cnt has the width of br_data_t.id and wraps to 0.
  - A CLEAR push: not enqueued, id_cnt unchanged, tx_err_o = 1 the next cycle.
  - No push while full. No bypass: pushes into an empty FIFO still take one cycle.
- TX FSM:
  - TX_IDLE: if FIFO non-empty && !local_busy_i → TX_REQ. At that edge, register flit_o ← head and set req_o ← 1.
  - TX_REQ: req_o and flit_o stay stable until ack_i is sampled high. At that edge: req_o ← 0, pop head → TX_GAP.
  - TX_GAP: one cycle with req_o = 0 → TX_IDLE. This guarantees a low cycle between requests even when busy is absent (e.g. router ignored a duplicate).
  - local_busy_i rising during TX_REQ does not withdraw req_o.
  - Latency from push into an empty FIFO to req_o high, with busy low: 2 cycles.
- RX FSM:
  - RX_IDLE: if req_i && !rx_full → write flit_i into the RX FIFO at that edge → RX_ACK.
  - If rx_full, stay in RX_IDLE with ack_o = 0; the router holds req_i.
  - RX_ACK: ack_o = 1 for exactly one cycle (registered) → RX_WAIT.
  - RX_WAIT: stay until req_i == 0 → RX_IDLE. A level-high req_i is never double-captured.
- RX FIFO:
  - rx_valid_o = non-empty; rx_data_o = head.
  - Pop on rx_valid_o && rx_ready_i.
  - Simultaneous push and pop when full is not possible (push is gated by full).
  - Simultaneous push and pop when non-full: count unchanged.
  - rx_valid_o rises the cycle after capture.
- FIFO pointers have log2(DEPTH)+1 bits; full/empty are derived from pointer MSB comparison.

Test Plan:
- Single push {ALL, tgt 0x0102, payload 0xAB}, SEQ_ADDRESS = 0x0005, busy low → req_o high 2 cycles later with flit_o.seq_source = 0x0005, id = 0. After ack_i pulse: req_o low next cycle, FIFO empty, tx_ready_o = 1.
- Busy gating: preload 2 entries; raise local_busy_i after the first ack; hold 50 cycles → no req_o during busy. Release busy → second flit sent with id = 1.
- Full/back-pressure and wrap: push TX_DEPTH+1 entries with no ack → tx_ready_o = 0 after TX_DEPTH pushes and the extra push is not taken. Run 2^idwidth+1 transfers → ids wrap to 0.
- CLEAR push → tx_err_o single pulse, no enqueue, next valid push receives the unchanged id.
- RX: router-model req_i held until ack → exactly one ack_o pulse per flit, rx_valid_o next cycle with identical data. With rx_ready_i = 0, fill RX_DEPTH flits → ack_o withheld for flit RX_DEPTH+1 until one pop, then acked.
- Reset asserted during TX_REQ and RX_WAIT → req_o, ack_o, rx_valid_o immediately 0. After release: FIFOs empty, next push gets id 0.
